load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface, placed between the pipeline MEM stage and the word-addressed data memory.
- The memory has a combinational read, a write on the posedge, and drops address bits [1:0].
- Accepts byte, halfword and word loads and stores. Sub-word stores are done as read-modify-write. Raises req_ready low (stall) while busy and returns one response per request.

Parameters:
- MEM_DEPTH, 20, number of 32-bit words in the attached memory. Used only by the optional bounds check.

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present; requester holds all req_* fields stable until accepted
- req_ready  output  1  high only in IDLE; acceptance = req_valid && req_ready at posedge
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle pulse per accepted request
- resp_err  output  1  valid with resp_valid: misaligned (or out of bounds)
- resp_rdata  output  32  load result, extended; 0 for stores and errors; held between responses
- mem_address  output  32  {captured_addr[31:2], 2'b00}
- mem_wd  output  32  write data to memory
- mem_write  output  1  memory write enable
- mem_rd  input  32  combinational read data from memory

Behaviour:
- States: IDLE, LOAD, RMW_READ, STORE, DONE.
- Reset values (asynchronous):
  - state = IDLE, so req_ready = 1.
  - resp_valid, resp_err, mem_write = 0.
  - resp_rdata, mem_wd and the captured addr/data/size = 0, so mem_address = 0.
- Outputs are decoded from state and registers: mem_write = (state==STORE), resp_valid = (state==DONE), req_ready = (state==IDLE).
- Byte lanes are little-endian: byte lane = addr[1:0] (lane 0 = [7:0]); half lane = addr[1].
- Misaligned if size==half and addr[0]==1, or size==word and addr[1:0]!=0.
- Transitions at the accept edge E0, taken from IDLE:
  - Misaligned: go to DONE with err=1. No memory access.
  - Load: go to LOAD.
  - Word store: go to STORE with mem_wd = wdata.
  - Byte or half store: go to RMW_READ.
- LOAD: at E1, extract the addressed lane from mem_rd, extend it, register into resp_rdata, go to DONE. resp_valid is high in the cycle after E1.
- RMW_READ: at E1, merge the wdata lane into mem_rd, keeping the other bytes, register into mem_wd, go to STORE.
- STORE: mem_write is high for exactly one cycle, then go to DONE.
- DONE: one cycle, then IDLE. A new request can be accepted at the edge that leaves DONE + 1 (no back-to-back overlap).
- Latency from accept to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
- req_valid while busy is ignored; the held request is accepted once back in IDLE.
- Reset mid-operation: immediate return to IDLE. mem_write drops asynchronously. The pending request is discarded with no response and no partial write.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
  - Defined: a request with addr[31:2] >= MEM_DEPTH is treated like a misaligned access: DONE with resp_err=1, no memory access.
  - Undefined: no range check; the address is passed through unchanged.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - a misalignment-check function.
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge, selected by size, lane and unsigned.

Test Plan:
- Preload word1 (addr 0x4) = 0x8899AABB. LW 0x4 -> resp_rdata 0x8899AABB, resp_valid 2 cycles after accept, mem_write never high.
- LB 0x7 -> 0xFFFFFF88. LBU 0x7 -> 0x00000088. LH 0x6 -> 0xFFFF8899. LHU 0x4 -> 0x0000AABB.
- SB 0x5, wdata 0x000000CC -> one mem_write with mem_wd 0x8899CCBB, 2 cycles after accept, resp 3 cycles after accept; a following LW 0x4 returns 0x8899CCBB.
- SW 0x2 and LH 0x3 -> resp_err=1 and resp_rdata 0 one cycle after accept, no mem_write, req_ready high the cycle after.
- rst low during RMW_READ of SB 0x4 -> mem_write never pulses, word1 unchanged, after release req_ready=1 and resp_valid=0.
- LW 0x50 (word 20): with LSU_BOUNDS_CHECK_EN -> resp_err=1, no access; without the macro -> normal access, resp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: access-size encodings, FSM state type and the alignment check.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRmwRead,
      StStore,
      StDone
   } lsu_state_t;

   // Size 2'b11 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = lane[0];
         default: is_misaligned = (lane != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit (little-endian).
// Ports:
//   size, lane, is_unsigned : access shape (lane = byte address bits [1:0])
//   rd_word                 : word read from memory
//   wdata                   : right-aligned store data
//   load_data               : addressed lane extracted and sign/zero-extended
//   store_word              : rd_word with the addressed lane replaced by wdata
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      rd_byte    = rd_word[{lane, 3'b000} +: 8];
      rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
      load_data  = rd_word;
      store_word = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = {{24{rd_byte[7] & ~is_unsigned}}, rd_byte};
            store_word = rd_word;
            store_word[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data  = {{16{rd_half[15] & ~is_unsigned}}, rd_half};
            store_word = rd_word;
            if (lane[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         default: begin
            load_data  = rd_word;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator between the MEM stage and a word-addressed data memory
// with combinational read and posedge write. Sub-word stores are read-modify-write.
// Optional build macro: LSU_BOUNDS_CHECK_EN (reject word index >= MEM_DEPTH).
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready handshake; req_write, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid pulse, resp_err, resp_rdata (held between responses)
//   mem_address, mem_wd, mem_write, mem_rd : memory side
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wd,
   output logic        mem_write,
   input  logic [31:0] mem_rd
);

   lsu_state_t  state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] rdata_q;
   logic [31:0] wd_q;
   logic        err_q;

   logic        bounds_err;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] store_word;

`ifdef LSU_BOUNDS_CHECK_EN
   assign bounds_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
`else
   // No range check in this build; the term is constant zero.
   assign bounds_err = 1'b0 && (MEM_DEPTH != 0);
`endif

   assign req_err = is_misaligned(req_size, req_addr[1:0]) || bounds_err;

   lsu_lane_align u_lane_align (
      .size        (size_q),
      .lane        (addr_q[1:0]),
      .is_unsigned (unsigned_q),
      .rd_word     (mem_rd),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= SZ_BYTE;
         unsigned_q <= 1'b0;
         rdata_q    <= '0;
         wd_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  if (req_err) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                     state_q <= StDone;
                  end else begin
                     err_q <= 1'b0;
                     if (!req_write) begin
                        state_q <= StLoad;
                     end else begin
                        rdata_q <= '0;
                        // size[1] covers both word and the reserved 2'b11 encoding
                        if (req_size[1]) begin
                           wd_q    <= req_wdata;
                           state_q <= StStore;
                        end else begin
                           state_q <= StRmwRead;
                        end
                     end
                  end
               end
            end
            StLoad: begin
               rdata_q <= load_data;
               state_q <= StDone;
            end
            StRmwRead: begin
               wd_q    <= store_word;
               state_q <= StStore;
            end
            StStore: state_q <= StDone;
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign resp_valid  = (state_q == StDone);
   assign mem_write   = (state_q == StStore);
   assign resp_err    = err_q;
   assign resp_rdata  = rdata_q;
   assign mem_wd      = wd_q;
   assign mem_address = {addr_q[31:2], 2'b00};

endmodule
